// File: rtl/sequenciador_leds_pkg.sv
// ============================================================================
// Module  : sequenciador_leds_pkg
// Brief   : State encodings, debug codes and default timing constants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sequenciador_leds_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ESPERA  = 3'd2,
    ACENDE  = 3'd3,
    APAGA   = 3'd4,
    FIM     = 3'd5
  } estado_t;

  localparam logic [3:0] c_DB_INVALIDO     = 4'hB;
  localparam int         c_T_ON_PADRAO     = 500;
  localparam int         c_T_OFF_PADRAO    = 500;
  localparam int         c_TIMER_W_PADRAO  = 16;

  function automatic logic [3:0] codigo_debug(input estado_t estado);
    case (estado)
      OCIOSO:  return 4'h0;
      CARREGA: return 4'h1;
      ESPERA:  return 4'h2;
      ACENDE:  return 4'h3;
      APAGA:   return 4'h4;
      FIM:     return 4'h5;
      default: return c_DB_INVALIDO;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sequenciador_leds_temporizador_led.sv
// ============================================================================
// Module  : temporizador_led
// Brief   : Up-counter with clear/enable and terminal compare against a
//           runtime limit; shared by the lit and dark phases.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module temporizador_led #(
  parameter int TIMER_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               zera,
  input  logic               conta,
  input  logic [TIMER_W-1:0] limite,
  output logic               fim
);

  logic [TIMER_W-1:0] r_contagem;

  // Clear has priority so a phase change always restarts from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_contagem <= '0;
    end else if (zera) begin
      r_contagem <= '0;
    end else if (conta) begin
      r_contagem <= r_contagem + 1'b1;
    end
  end

  assign fim = (r_contagem == limite);

endmodule

`default_nettype wire

// File: rtl/sequenciador_leds.sv
// ============================================================================
// Module  : sequenciador_leds
// Brief   : Plays ROM patterns 0..nivel on the LEDs, T_ON lit then T_OFF dark.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sequenciador_leds
  import sequenciador_leds_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int T_ON    = c_T_ON_PADRAO,
  parameter int T_OFF   = c_T_OFF_PADRAO,
  parameter int TIMER_W = c_TIMER_W_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] nivel,
  input  logic [DATA_W-1:0] rom_dado,
  output logic [ADDR_W-1:0] rom_endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ocupado,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam logic [TIMER_W-1:0] c_LIM_ON  = TIMER_W'(T_ON - 1);
  localparam logic [TIMER_W-1:0] c_LIM_OFF = TIMER_W'(T_OFF - 1);

  estado_t             r_estado;
  estado_t             w_proximo;
  logic [ADDR_W-1:0]   r_indice;
  logic [ADDR_W-1:0]   r_nivel;
  logic [DATA_W-1:0]   r_led;
  logic                w_fim_tempo;
  logic                w_zera;
  logic                w_conta;
  logic [TIMER_W-1:0]  w_limite;
  logic                w_ultimo;

  assign w_ultimo = (r_indice == r_nivel);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_proximo;
    end
  end

  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      OCIOSO:  if (iniciar) w_proximo = CARREGA;
      CARREGA: w_proximo = ESPERA;
      ESPERA:  w_proximo = ACENDE;
      ACENDE:  if (w_fim_tempo) w_proximo = APAGA;
      APAGA:   if (w_fim_tempo) w_proximo = w_ultimo ? FIM : CARREGA;
      FIM:     w_proximo = OCIOSO;
      default: w_proximo = OCIOSO;
    endcase
    if (abortar) begin
      w_proximo = OCIOSO;
    end
  end

  // Terminal check precedes the increment, so the index never wraps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_indice <= '0;
      r_nivel  <= '0;
      r_led    <= '0;
    end else if (abortar) begin
      r_led <= '0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (iniciar) begin
            r_indice <= '0;
            r_nivel  <= nivel;
          end
        end
        ESPERA: r_led <= rom_dado;
        APAGA: begin
          if (w_fim_tempo && !w_ultimo) begin
            r_indice <= r_indice + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Every state transition (including abort) restarts the timer.
  assign w_zera   = (w_proximo != r_estado);
  assign w_conta  = (r_estado == ACENDE) || (r_estado == APAGA);
  assign w_limite = (r_estado == APAGA) ? c_LIM_OFF : c_LIM_ON;

  temporizador_led #(
    .TIMER_W (TIMER_W)
  ) u_temporizador (
    .clock  (clock),
    .reset  (reset),
    .zera   (w_zera),
    .conta  (w_conta),
    .limite (w_limite),
    .fim    (w_fim_tempo)
  );

  assign rom_endereco = r_indice;
  assign leds         = (r_estado == ACENDE) ? r_led : '0;
  assign ocupado      = (r_estado != OCIOSO);
  assign pronto       = (r_estado == FIM);
  assign db_estado    = codigo_debug(r_estado);

endmodule

`default_nettype wire

// File: tb/tb_sequenciador_leds.sv
// ============================================================================
// Module  : tb_sequenciador_leds
// Brief   : Directed bench for sequenciador_leds with T_ON=3, T_OFF=2.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequenciador_leds;

  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 4;
  localparam int T_ON    = 3;
  localparam int T_OFF   = 2;
  localparam int TIMER_W = 16;
  localparam int PERIODO = 2 + T_ON + T_OFF;

  logic              clock;
  logic              reset;
  logic              iniciar;
  logic              abortar;
  logic [ADDR_W-1:0] nivel;
  logic [DATA_W-1:0] rom_dado;
  logic [ADDR_W-1:0] rom_endereco;
  logic [DATA_W-1:0] leds;
  logic              ocupado;
  logic              pronto;
  logic [3:0]        db_estado;

  logic [DATA_W-1:0] rom_mem [16];

  int tests_run = 0;
  int failed    = 0;

  sequenciador_leds #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .T_ON    (T_ON),
    .T_OFF   (T_OFF),
    .TIMER_W (TIMER_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .abortar      (abortar),
    .nivel        (nivel),
    .rom_dado     (rom_dado),
    .rom_endereco (rom_endereco),
    .leds         (leds),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clock) rom_dado <= rom_mem[rom_endereco];

  // Observation packing: {leds, ocupado, pronto, rom_endereco, db_estado}
  function automatic logic [13:0] observado();
    return {leds, ocupado, pronto, rom_endereco, db_estado};
  endfunction

  // Timeline model: cycle n counts edges, the accepting edge being edge 1.
  function automatic logic [13:0] esperado(input int n, input int nv);
    int total;
    int e;
    int o;
    logic [3:0] st;
    logic [3:0] lv;
    total = (nv + 1) * PERIODO;
    st = 4'd0;
    e  = nv;
    if (n >= 1 && n <= total) begin
      e = (n - 1) / PERIODO;
      o = (n - 1) % PERIODO;
      if (o == 0)              st = 4'd1;
      else if (o == 1)         st = 4'd2;
      else if (o < 2 + T_ON)   st = 4'd3;
      else                     st = 4'd4;
    end else if (n == total + 1) begin
      st = 4'd5;
    end
    lv = (st == 4'd3) ? rom_mem[e] : 4'd0;
    return {lv, (st != 4'd0), (st == 4'd5), 4'(e), st};
  endfunction

  task automatic test_reset;
    logic [13:0] obs;
    reset = 1'b0; iniciar = 1'b0; abortar = 1'b0; nivel = '0;
    repeat (2) @(negedge clock);
    obs = observado();
    tests_run++;
    if (obs !== 14'd0) begin
      failed++;
      $display("FAIL reset_state: got %h expected %h", obs, 14'd0);
    end
    reset = 1'b1;
    @(negedge clock);
    obs = observado();
    tests_run++;
    if (obs !== 14'd0) begin
      failed++;
      $display("FAIL idle_after_reset: got %h expected %h", obs, 14'd0);
    end
  endtask

  task automatic test_single;
    logic [13:0] obs, exp;
    int pulsos = 0;
    rom_mem[0] = 4'b0010;
    nivel = 4'd0; iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      obs = observado(); exp = esperado(n, 0);
      tests_run++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL single cycle %0d: got %h expected %h", n, obs, exp);
      end
      if (pronto) pulsos++;
      @(negedge clock);
    end
    tests_run++;
    if (pulsos !== 1) begin
      failed++;
      $display("FAIL single_pronto_count: got %0d expected 1", pulsos);
    end
  endtask

  task automatic test_multi;
    logic [13:0] obs, exp;
    int pulsos = 0;
    rom_mem[0] = 4'b0001; rom_mem[1] = 4'b0010; rom_mem[2] = 4'b0100;
    nivel = 4'd2; iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      obs = observado(); exp = esperado(n, 2);
      tests_run++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL multi cycle %0d: got %h expected %h", n, obs, exp);
      end
      if (pronto) pulsos++;
      @(negedge clock);
    end
    tests_run++;
    if (pulsos !== 1) begin
      failed++;
      $display("FAIL multi_pronto_count: got %0d expected 1", pulsos);
    end
  endtask

  task automatic test_ignore_iniciar;
    logic [13:0] obs, exp;
    int pulsos = 0;
    nivel = 4'd2; iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      obs = observado(); exp = esperado(n, 2);
      tests_run++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL ignore cycle %0d: got %h expected %h", n, obs, exp);
      end
      if (pronto) pulsos++;
      iniciar = (n <= 21) && (n % 2 == 1);
      if (n == 5) nivel = 4'hF;
      @(negedge clock);
    end
    iniciar = 1'b0;
    tests_run++;
    if (pulsos !== 1) begin
      failed++;
      $display("FAIL ignore_pronto_count: got %0d expected 1", pulsos);
    end
  endtask

  task automatic test_abort;
    logic [13:0] obs, exp;
    int pulsos = 0;
    nivel = 4'd2; iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      obs = observado(); exp = esperado(n, 2);
      tests_run++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL abort_pre cycle %0d: got %h expected %h", n, obs, exp);
      end
      @(negedge clock);
      if (n == 12) abortar = 1'b1;
    end
    // cycle 13 was the second entry's first dark cycle; abort took effect
    abortar = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (pronto) pulsos++;
      tests_run++;
      if ({leds, ocupado, db_estado} !== 9'd0) begin
        failed++;
        $display("FAIL abort_idle %0d: got leds=%h ocupado=%b db=%h expected 0,0,0",
                 k, leds, ocupado, db_estado);
      end
      @(negedge clock);
    end
    tests_run++;
    if (pulsos !== 0) begin
      failed++;
      $display("FAIL abort_no_pronto: got %0d expected 0", pulsos);
    end
    abortar = 1'b1; iniciar = 1'b1;
    @(negedge clock);
    abortar = 1'b0; iniciar = 1'b0;
    tests_run++;
    if ({ocupado, db_estado} !== 5'd0) begin
      failed++;
      $display("FAIL abort_beats_iniciar: got ocupado=%b db=%h expected 0,0", ocupado, db_estado);
    end
    nivel = 4'd1; iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      obs = observado(); exp = esperado(n, 1);
      tests_run++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL restart cycle %0d: got %h expected %h", n, obs, exp);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_full;
    logic [13:0] obs, exp;
    int pulsos = 0;
    int pronto_ciclo = -1;
    for (int i = 0; i < 16; i++) rom_mem[i] = 4'hF;
    nivel = 4'hF; iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    for (int n = 1; n <= 116; n++) begin
      obs = observado(); exp = esperado(n, 15);
      tests_run++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL full cycle %0d: got %h expected %h", n, obs, exp);
      end
      if (pronto) begin pulsos++; pronto_ciclo = n; end
      @(negedge clock);
    end
    tests_run++;
    if (pulsos !== 1 || pronto_ciclo !== 113) begin
      failed++;
      $display("FAIL full_pronto: got count=%0d cycle=%0d expected count=1 cycle=113",
               pulsos, pronto_ciclo);
    end
  endtask

  task automatic test_reset_mid;
    logic [13:0] obs, exp;
    int pulsos = 0;
    rom_mem[0] = 4'b1010;
    nivel = 4'd0; iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      obs = observado(); exp = esperado(n, 0);
      tests_run++;
      if (obs !== exp) begin
        failed++;
        $display("FAIL resetmid_pre cycle %0d: got %h expected %h", n, obs, exp);
      end
      if (n < 4) @(negedge clock);
    end
    #2 reset = 1'b0;
    #1;
    obs = observado();
    tests_run++;
    if (obs !== 14'd0) begin
      failed++;
      $display("FAIL reset_async: got %h expected %h", obs, 14'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (pronto) pulsos++;
      @(negedge clock);
    end
    obs = observado();
    tests_run++;
    if (obs !== 14'd0 || pulsos !== 0) begin
      failed++;
      $display("FAIL reset_mid_after: got obs=%h pronto=%0d expected obs=0 pronto=0", obs, pulsos);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = 4'd0;
    test_reset();
    test_single();
    test_multi();
    test_ignore_iniciar();
    test_abort();
    test_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

`default_nettype wire
